// File: rtl/shift_window_ctrl_if.sv
// Stream, window and datapath signals of the shift-window controller.
// The controller sits on the slave side; the driving environment uses master.
interface shift_window_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sof;
    logic        sp_write_en;
    logic [31:0] sp_data_in;
    logic        win_valid;
    logic        win_ready;
    logic [7:0]  win_row;
    logic [6:0]  win_col;
    logic        frame_done;
    logic        sof_err;

    // Handshakes: a word moves when in_valid & in_ready on a rising clk edge;
    // a window is consumed when win_valid & win_ready on a rising clk edge.
    // Valids hold their payload stable until the matching ready is seen.
    modport slave (
        input  in_valid, in_data, in_sof, win_ready,
        output in_ready, sp_write_en, sp_data_in, win_valid, win_row, win_col,
               frame_done, sof_err
    );

    modport master (
        output in_valid, in_data, in_sof, win_ready,
        input  in_ready, sp_write_en, sp_data_in, win_valid, win_row, win_col,
               frame_done, sof_err
    );
endinterface

// File: rtl/shift_window_ctrl.sv
// Sequences the three-line shift datapath: one shift per accepted word, tracks
// row/column and flags windows that hold three real lines of the current frame.
module shift_window_ctrl #(
    parameter int WORDS_PER_LINE  = 84,
    parameter int LINES_PER_FRAME = 240
) (
    input  logic                 clk,
    input  logic                 reset,
    shift_window_ctrl_if.slave   bus,
    output logic [1:0]           dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [6:0] COL_LAST = 7'(WORDS_PER_LINE - 1);
    localparam logic [7:0] ROW_LAST = 8'(LINES_PER_FRAME - 1);

    state_e      state_q, state_d;
    logic [7:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic        win_valid_q, win_valid_d;
    logic [7:0]  win_row_q, win_row_d;
    logic [6:0]  win_col_q, win_col_d;
    logic        frame_done_q, frame_done_d;
    logic        sof_err_q, sof_err_d;

    logic        in_ready;
    logic        accept;
    logic        shift;
    logic [7:0]  word_row;
    logic [6:0]  word_col;

    // An unconsumed window blocks input so the datapath cannot shift under it.
    assign in_ready = !reset && (state_q != DONE) && !(win_valid_q && !bus.win_ready);
    assign accept   = bus.in_valid && in_ready;
    assign shift    = accept && ((state_q == RUN) || ((state_q == IDLE) && bus.in_sof));

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        win_valid_d  = win_valid_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = 1'b0;
        sof_err_d    = 1'b0;
        word_row     = row_q;
        word_col     = col_q;

        if (bus.in_sof) begin
            word_row = 8'd0;
            word_col = 7'd0;
        end

        if (win_valid_q && bus.win_ready) begin
            win_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: if (shift) state_d = RUN;
            RUN:  if (accept && bus.in_sof) sof_err_d = 1'b1;
            DONE: begin
                if (!win_valid_q) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (shift) begin
            // Col 0 straddles a line boundary; rows 0-1 still expose stale lines.
            win_valid_d = (word_row >= 8'd2) && (word_col != 7'd0);
            win_row_d   = word_row;
            win_col_d   = word_col;
            if (word_col == COL_LAST) begin
                col_d = 7'd0;
                row_d = word_row + 8'd1;
                if (word_row == ROW_LAST) begin
                    state_d = DONE;
                    row_d   = 8'd0;
                end
            end else begin
                col_d = word_col + 7'd1;
                row_d = word_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            row_q        <= 8'd0;
            col_q        <= 7'd0;
            win_valid_q  <= 1'b0;
            win_row_q    <= 8'd0;
            win_col_q    <= 7'd0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.sp_write_en = shift;
    assign bus.sp_data_in  = bus.in_data;
    assign bus.win_valid   = win_valid_q;
    assign bus.win_row     = win_row_q;
    assign bus.win_col     = win_col_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.sof_err     = sof_err_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_shift_window_ctrl.sv
// Directed bench for shift_window_ctrl with an 8-word x 4-line frame.
module tb_shift_window_ctrl;
    localparam int WPL = 8;
    localparam int LPF = 4;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         win_cnt = 0;
    int         fd_cnt = 0;

    shift_window_ctrl_if bus ();

    shift_window_ctrl #(.WORDS_PER_LINE(WPL), .LINES_PER_FRAME(LPF)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Consumed windows and frame_done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && bus.win_valid && bus.win_ready) win_cnt <= win_cnt + 1;
        if (!reset && bus.frame_done) fd_cnt <= fd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input bit sof, input bit exp_we);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = sof;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (bus.in_ready) begin
                ok = 1'b1;
                check("sp_write_en", 32'(bus.sp_write_en), 32'(exp_we));
                check("sp_data_in", bus.sp_data_in, d);
            end
            step();
            if (ok) break;
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        check("push_accepted", 32'(ok), 32'd1);
    endtask

    // Words first..last of a frame; window status checked after each accept.
    task automatic push_range(input int first, input int last, input bit sof_first);
        int r, c;
        bit exp_v;
        for (int i = first; i <= last; i++) begin
            push(32'hA500_0000 + 32'(i), sof_first && (i == first), 1'b1);
            r = i / WPL;
            c = i % WPL;
            exp_v = (r >= 2) && (c >= 1);
            check("win_valid", 32'(bus.win_valid), 32'(exp_v));
            if (exp_v) begin
                check("win_row", 32'(bus.win_row), 32'(r));
                check("win_col", 32'(bus.win_col), 32'(c));
            end
        end
    endtask

    task automatic wait_done();
        int n;
        int fd0;
        n = 0;
        fd0 = fd_cnt;
        check("done_state", 32'(dbg_state), 32'(S_DONE));
        check("done_in_ready", 32'(bus.in_ready), 32'd0);
        while (!bus.frame_done && n < 10) begin
            step();
            n++;
        end
        check("frame_done_seen", 32'(bus.frame_done), 32'd1);
        check("frame_done_latency", 32'(n), 32'd2);
        check("idle_after_done", 32'(dbg_state), 32'(S_IDLE));
        step();
        check("frame_done_one_cycle", 32'(bus.frame_done), 32'd0);
        check("frame_done_count", 32'(fd_cnt - fd0), 32'd1);
    endtask

    initial begin
        int w0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h1234_5678;
        bus.in_sof    = 1'b1;
        bus.win_ready = 1'b1;
        reset = 1'b1;
        step();
        step();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_write_en", 32'(bus.sp_write_en), 32'd0);
        check("rst_win_valid", 32'(bus.win_valid), 32'd0);
        check("rst_win_row", 32'(bus.win_row), 32'd0);
        check("rst_win_col", 32'(bus.win_col), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_sof_err", 32'(bus.sof_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        reset = 1'b0;
        step();

        // Plain frame, consumer always ready.
        w0 = win_cnt;
        push_range(0, 31, 1'b1);
        wait_done();
        check("t1_windows", 32'(win_cnt - w0), 32'd14);

        // Consumer stalls 5 cycles at the first window.
        w0 = win_cnt;
        push_range(0, 17, 1'b1);
        bus.win_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA500_0000 + 32'd18;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_write_en", 32'(bus.sp_write_en), 32'd0);
            check("stall_win_row", 32'(bus.win_row), 32'd2);
            check("stall_win_col", 32'(bus.win_col), 32'd1);
            step();
        end
        bus.win_ready = 1'b1;
        push_range(18, 31, 1'b0);
        wait_done();
        check("t2_windows", 32'(win_cnt - w0), 32'd14);

        // Non-sof words in IDLE are dropped without a shift.
        w0 = win_cnt;
        for (int k = 0; k < 3; k++) push(32'hDEAD_0000 + 32'(k), 1'b0, 1'b0);
        check("drop_state", 32'(dbg_state), 32'(S_IDLE));
        check("drop_win_valid", 32'(bus.win_valid), 32'd0);
        push_range(0, 31, 1'b1);
        wait_done();
        check("t3_windows", 32'(win_cnt - w0), 32'd14);

        // Mid-frame sof at row 2, col 3 restarts the frame.
        w0 = win_cnt;
        push_range(0, 18, 1'b1);
        push_range(0, 0, 1'b1);
        check("sof_err_pulse", 32'(bus.sof_err), 32'd1);
        check("sof_err_state", 32'(dbg_state), 32'(S_RUN));
        push_range(1, 31, 1'b0);
        check("sof_err_cleared", 32'(bus.sof_err), 32'd0);
        wait_done();
        check("t4_windows", 32'(win_cnt - w0), 32'd16);

        // One-cycle reset at row 3, col 2 with a pending window.
        push_range(0, 25, 1'b1);
        check("pre_rst_win_valid", 32'(bus.win_valid), 32'd1);
        bus.win_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_win_valid", 32'(bus.win_valid), 32'd0);
        check("mid_rst_win_row", 32'(bus.win_row), 32'd0);
        check("mid_rst_win_col", 32'(bus.win_col), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("mid_rst_sof_err", 32'(bus.sof_err), 32'd0);
        check("mid_rst_frame_done", 32'(bus.frame_done), 32'd0);
        bus.win_ready = 1'b1;
        w0 = win_cnt;
        push_range(0, 31, 1'b1);
        wait_done();
        check("t5_windows", 32'(win_cnt - w0), 32'd14);

        // Back-to-back frames: wait_done leaves us one cycle after frame_done.
        w0 = win_cnt;
        push_range(0, 31, 1'b1);
        wait_done();
        check("t6_windows", 32'(win_cnt - w0), 32'd14);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/shift_window_ctrl.md
# shift_window_ctrl

Sequencing controller for the three-line shift data path of the edge detector. Accepts a frame of packed 32-bit pixel words over a valid/ready stream and drives the datapath `write_en`/`data_in` one shift per accepted word. Tracks row/column position and marks when the six-word window `w0..w5` holds three real lines of the current frame. Stalls the input whenever the downstream convolution engine has not yet taken the current window.

## Interface
- `WORDS_PER_LINE`, 84: words per image line; equals the line-to-line delay of the datapath (8-word shift + 76-entry buffer). Range 2..128.
- `LINES_PER_FRAME`, 240: lines per frame. Range 3..256.

- `clk`  in  1  clock; one clock, all logic on rising edge
- `reset`  in  1  reset is synchronous and active-high
- `in_valid`  in  1  input word present
- `in_ready`  out  1  controller accepts `in_data` this cycle
- `in_data`  in  32  packed pixel word
- `in_sof`  in  1  qualifies `in_data` as first word of a frame
- `sp_write_en`  out  1  datapath shift enable
- `sp_data_in`  out  32  datapath input word
- `win_valid`  out  1  window `w0..w5` is a complete current-frame window
- `win_ready`  in  1  downstream consumes window
- `win_row`  out  8  line index of newest word in window
- `win_col`  out  7  word index of newest word in window
- `frame_done`  out  1  one-cycle pulse after last window of frame is consumed
- `sof_err`  out  1  one-cycle pulse: `in_sof` seen mid-frame

## Operation
- Accept = `in_valid & in_ready`. `sp_write_en` = accept while in RUN, or accept with `in_sof` while in IDLE. `sp_data_in` = `in_data` combinationally. The datapath shifts on the same edge.
- `in_ready` = 0 during `reset`, 0 in DONE, 0 while `win_valid & ~win_ready`; otherwise 1.
- States:
  - IDLE: words without `in_sof` are accepted and dropped, with no shift. An sof word shifts, sets row=0/col=0 and enters RUN.
  - RUN: each accepted word advances col. When col=`WORDS_PER_LINE`-1, col wraps to 0 and row increments.
  - RUN to DONE: the accepted word has row=`LINES_PER_FRAME`-1 and col=`WORDS_PER_LINE`-1.
  - DONE: wait until `win_valid` clears, pulse `frame_done` for one cycle, return to IDLE.
- `in_sof` in RUN (accepted): pulse `sof_err` and treat the word as a new frame start (row=0, col=0, stay RUN). Any pending `win_valid` is not withdrawn.
- Window qualification: after an accepted shift whose word has row ≥ 2 and col ≥ 1, register `win_valid`=1 with `win_row`/`win_col` of that word. Otherwise `win_valid`=0 after the shift.
  - Col 0 windows straddle a line boundary and are never flagged.
  - Rows 0-1 would expose stale buffer contents from the previous frame and are never flagged. The datapath has no reset; this qualification is the only stale-data protection.
- `win_valid` holds with stable `win_row`/`win_col` until `win_ready`. If `win_ready` and a new accept coincide, the register loads the new word's status directly (no bubble).
- Counter widths: row 8 bits, col 7 bits. No arithmetic overflow within the parameter range.

## Timing
- Reset values: state IDLE, row 0, col 0, `win_valid` 0, `win_row` 0, `win_col` 0, `frame_done` 0, `sof_err` 0. `sp_write_en` and `in_ready` are 0 while `reset` is high.
- Accept at edge N: shift at edge N. `win_valid`/`win_row`/`win_col` are valid in the cycle after edge N (latency 1).
- Throughput: one word per cycle when `win_ready` is held high.
- `frame_done` rises the cycle after DONE observes `win_valid`=0, and lasts exactly 1 cycle.
- `sof_err` rises the cycle after the offending accept, and lasts 1 cycle.
- Reset mid-frame: on the next cycle all state is at reset values; `win_valid` drops immediately. Datapath contents are left as-is and are masked by row qualification.

## Test plan
- Params 8/4. Stream 32 words starting with sof, `win_ready`=1 → exactly 2×7=14 `win_valid` cycles, first with row=2/col=1 one cycle after word 17 is accepted. `frame_done` pulses once, 2 cycles after word 31.
- Same stream with `win_ready` low for 5 cycles at the first window → `in_ready`=0 and `sp_write_en`=0 for those 5 cycles. Window coordinates stay 2/1, and no words are lost (14 windows total).
- In IDLE, send 3 words without sof, then an sof frame → no shift for the first 3 words; first window appears at the same relative position as in the first test.
- Assert sof at row 2, col 3 → `sof_err` pulse. Row/col restart at 0, with no `win_valid` until row 2, col 1 of the new frame.
- Assert `reset` for 1 cycle at row 3, col 2 with `win_valid`=1 → next cycle all outputs are 0 and the state is IDLE. A subsequent full frame gives 14 windows.
- Back-to-back frames (sof on the cycle after `frame_done`) → second frame accepted. `in_ready` is low only during the DONE cycles.
